// File: rtl/bin_hist_pkg.sv
// Shared types, constants and the argmax helper for the bin histogram.
// Imported by bin_sat_counter and bin_histogram.
package bin_hist_pkg;

   typedef logic [1:0] bin_t;

   localparam int NUM_BINS  = 4;
   localparam int MAX_CNT_W = 16;

   typedef enum logic {
      ACCUM  = 1'b0,
      REPORT = 1'b1
   } state_t;

   // Counts arrive zero-extended to MAX_CNT_W each, bin i at slice i.
   // Strict '>' keeps the lower index on ties.
   function automatic bin_t argmax_lowest(
      input logic [NUM_BINS*MAX_CNT_W-1:0] c
   );
      bin_t                 best;
      logic [MAX_CNT_W-1:0] best_v;
      best   = '0;
      best_v = c[MAX_CNT_W-1:0];
      for (int i = 1; i < NUM_BINS; i++) begin
         if (c[i*MAX_CNT_W +: MAX_CNT_W] > best_v) begin
            best_v = c[i*MAX_CNT_W +: MAX_CNT_W];
            best   = bin_t'(i);
         end
      end
      return best;
   endfunction

endpackage

// File: rtl/bin_histogram_sat_counter.sv
// Saturating per-bin counter with synchronous clear.
// Ports: clk, rst_n, clr, inc -> count, sat_hit (inc attempted at max).
module bin_sat_counter
   import bin_hist_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             sat_hit
);

   localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

   logic at_max;

   assign at_max  = (count == MAX);
   assign sat_hit = inc && at_max && !clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !at_max) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/bin_histogram.sv
// Windowed 4-bin histogram of a valid/ready bin-code stream.
// Ports: clk, rst_n, clear, bin_valid/bin_code/bin_ready in,
//        hist_valid/hist_ready, hist_counts, hist_dominant, hist_sat out.
module bin_histogram
   import bin_hist_pkg::*;
#(
   parameter int WINDOW = 16,
   parameter int CNT_W  = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   input  logic                      bin_valid,
   input  logic [1:0]                bin_code,
   output logic                      bin_ready,
   output logic                      hist_valid,
   input  logic                      hist_ready,
   output logic [NUM_BINS*CNT_W-1:0] hist_counts,
   output logic [1:0]                hist_dominant,
   output logic                      hist_sat
);

   localparam int SC_W = $clog2(WINDOW + 1);
   localparam logic [SC_W-1:0] LAST = SC_W'(WINDOW - 1);

   state_t state_q, state_d;

   logic [SC_W-1:0]     samp_q;
   logic                sat_q;
   logic                accept;
   logic                hs;
   logic                clr_all;
   logic                last;
   logic [NUM_BINS-1:0] inc;
   logic [NUM_BINS-1:0] sat_hit;
   logic [CNT_W-1:0]    cnt [NUM_BINS];
   logic [NUM_BINS*MAX_CNT_W-1:0] wide;

   assign bin_ready  = (state_q == ACCUM) && !clear;
   assign hist_valid = (state_q == REPORT);

   assign accept  = bin_valid && bin_ready;
   assign hs      = hist_valid && hist_ready;
   // Handshake and clear both wipe the window; clear also wins the FSM.
   assign clr_all = clear || hs;
   assign last    = accept && (samp_q == LAST);

   for (genvar i = 0; i < NUM_BINS; i++) begin : g_bin
      assign inc[i] = accept && (bin_code == bin_t'(i));

      bin_sat_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk     (clk),
         .rst_n   (rst_n),
         .clr     (clr_all),
         .inc     (inc[i]),
         .count   (cnt[i]),
         .sat_hit (sat_hit[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samp_q <= '0;
      end else if (clr_all) begin
         samp_q <= '0;
      end else if (accept) begin
         samp_q <= samp_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_q <= 1'b0;
      end else if (clr_all) begin
         sat_q <= 1'b0;
      end else if (|sat_hit) begin
         sat_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ACCUM;
      end else begin
         unique case (state_q)
            ACCUM:  if (last) state_d = REPORT;
            REPORT: if (hist_ready) state_d = ACCUM;
            default: state_d = ACCUM;
         endcase
      end
   end

   always_comb begin
      hist_counts = '0;
      wide        = '0;
      for (int i = 0; i < NUM_BINS; i++) begin
         hist_counts[i*CNT_W +: CNT_W] = cnt[i];
         wide[i*MAX_CNT_W +: CNT_W]    = cnt[i];
      end
   end

   assign hist_dominant = argmax_lowest(wide);
   assign hist_sat      = sat_q;

endmodule

// File: tb/tb_bin_histogram.sv
// Self-checking bench for bin_histogram.
// Three instances: W=4/C=8, W=8/C=3, W=16/C=8 (randomized).
module tb_bin_histogram;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   // instance A: WINDOW=4, CNT_W=8
   logic        a_clr = 0, a_bv = 0, a_br, a_hv, a_hr = 0, a_sat;
   logic [1:0]  a_bc = 0, a_dom;
   logic [31:0] a_cnt;
   // instance B: WINDOW=8, CNT_W=3
   logic        b_clr = 0, b_bv = 0, b_br, b_hv, b_hr = 0, b_sat;
   logic [1:0]  b_bc = 0, b_dom;
   logic [11:0] b_cnt;
   // instance C: WINDOW=16, CNT_W=8
   logic        c_clr = 0, c_bv = 0, c_br, c_hv, c_hr = 0, c_sat;
   logic [1:0]  c_bc = 0, c_dom;
   logic [31:0] c_cnt;

   bin_histogram #(.WINDOW(4), .CNT_W(8)) u_a (
      .clk(clk), .rst_n(rst_n), .clear(a_clr),
      .bin_valid(a_bv), .bin_code(a_bc), .bin_ready(a_br),
      .hist_valid(a_hv), .hist_ready(a_hr), .hist_counts(a_cnt),
      .hist_dominant(a_dom), .hist_sat(a_sat)
   );

   bin_histogram #(.WINDOW(8), .CNT_W(3)) u_b (
      .clk(clk), .rst_n(rst_n), .clear(b_clr),
      .bin_valid(b_bv), .bin_code(b_bc), .bin_ready(b_br),
      .hist_valid(b_hv), .hist_ready(b_hr), .hist_counts(b_cnt),
      .hist_dominant(b_dom), .hist_sat(b_sat)
   );

   bin_histogram #(.WINDOW(16), .CNT_W(8)) u_c (
      .clk(clk), .rst_n(rst_n), .clear(c_clr),
      .bin_valid(c_bv), .bin_code(c_bc), .bin_ready(c_br),
      .hist_valid(c_hv), .hist_ready(c_hr), .hist_counts(c_cnt),
      .hist_dominant(c_dom), .hist_sat(c_sat)
   );

   int n_tot = 0;
   int n_pass = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic a_push(input logic [1:0] b);
      a_bv = 1'b1;
      a_bc = b;
      @(posedge clk); #1;
      a_bv = 1'b0;
   endtask

   task automatic b_push(input logic [1:0] b);
      b_bv = 1'b1;
      b_bc = b;
      @(posedge clk); #1;
      b_bv = 1'b0;
   endtask

   task automatic a_idle_chk(input string tag);
      chk({tag, "_cnt"}, a_cnt, 32'h0);
      chk({tag, "_dom"}, {30'h0, a_dom}, 32'h0);
      chk({tag, "_sat"}, {31'h0, a_sat}, 32'h0);
      chk({tag, "_hv"}, {31'h0, a_hv}, 32'h0);
      chk({tag, "_br"}, {31'h0, a_br}, 32'h1);
   endtask

   int          mc [4];
   int          best;
   int          wins;
   int          wcyc;
   int          sum;
   bit          reported;
   bit          hold;
   bit          tmo;
   logic [31:0] s_cnt;
   logic [1:0]  s_dom;
   logic        s_sat;
   logic [31:0] e_cnt;
   logic [3:0]  v4;

   initial begin
      a_hr = 1'b1;
      b_hr = 1'b1;
      #12;
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      a_idle_chk("rst");

      // window 0,1,1,3 with ready consumer
      @(posedge clk); #1;
      a_push(2'd0); a_push(2'd1); a_push(2'd1); a_push(2'd3);
      @(negedge clk);
      chk("t1_hv", {31'h0, a_hv}, 32'h1);
      chk("t1_br", {31'h0, a_br}, 32'h0);
      chk("t1_cnt", a_cnt, 32'h01000201);
      chk("t1_dom", {30'h0, a_dom}, 32'h1);
      chk("t1_sat", {31'h0, a_sat}, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      a_idle_chk("t1_post");

      // held report, tie goes low, bin_valid ignored
      @(posedge clk); #1;
      a_hr = 1'b0;
      a_push(2'd2); a_push(2'd2); a_push(2'd3); a_push(2'd3);
      for (int k = 0; k < 5; k++) begin
         a_bv = k[0];
         a_bc = 2'd1;
         @(negedge clk);
         chk("t2_hv", {31'h0, a_hv}, 32'h1);
         chk("t2_br", {31'h0, a_br}, 32'h0);
         chk("t2_cnt", a_cnt, 32'h02020000);
         chk("t2_dom", {30'h0, a_dom}, 32'h2);
         @(posedge clk); #1;
      end
      a_bv = 1'b0;
      a_hr = 1'b1;
      @(negedge clk);
      chk("t2_hv6", {31'h0, a_hv}, 32'h1);
      @(posedge clk); #1;
      @(negedge clk);
      a_idle_chk("t2_post");
      @(posedge clk); #1;
      a_push(2'd1);
      @(negedge clk);
      chk("t2_new", a_cnt, 32'h00000100);

      // saturation on the CNT_W=3 instance
      @(posedge clk); #1;
      for (int k = 0; k < 8; k++) b_push(2'd2);
      @(negedge clk);
      chk("t3_hv", {31'h0, b_hv}, 32'h1);
      chk("t3_cnt", {20'h0, b_cnt}, 32'h1C0);
      chk("t3_sat", {31'h0, b_sat}, 32'h1);
      chk("t3_dom", {30'h0, b_dom}, 32'h2);
      @(posedge clk); #1;
      for (int k = 0; k < 8; k++) b_push(2'(k));
      @(negedge clk);
      chk("t3b_hv", {31'h0, b_hv}, 32'h1);
      chk("t3b_cnt", {20'h0, b_cnt}, 32'h492);
      chk("t3b_sat", {31'h0, b_sat}, 32'h0);
      chk("t3b_dom", {30'h0, b_dom}, 32'h0);
      @(posedge clk); #1;

      // clear wins over a concurrent sample
      a_push(2'd1); a_push(2'd1);
      a_clr = 1'b1;
      a_bv  = 1'b1;
      a_bc  = 2'd1;
      @(negedge clk);
      chk("t4_br", {31'h0, a_br}, 32'h0);
      @(posedge clk); #1;
      a_clr = 1'b0;
      a_bv  = 1'b0;
      @(negedge clk);
      a_idle_chk("t4_clr");
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) a_push(2'd0);
      @(negedge clk);
      chk("t4_hv", {31'h0, a_hv}, 32'h1);
      chk("t4_cnt", a_cnt, 32'h00000004);
      chk("t4_dom", {30'h0, a_dom}, 32'h0);
      @(posedge clk); #1;

      // async reset mid-window and mid-report
      a_push(2'd1); a_push(2'd2); a_push(2'd3);
      #2 rst_n = 1'b0;
      #1 a_idle_chk("t5_rw");
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      a_hr = 1'b0;
      for (int k = 0; k < 4; k++) a_push(2'd0);
      @(negedge clk);
      chk("t5_hv", {31'h0, a_hv}, 32'h1);
      #1 rst_n = 1'b0;
      #1 a_idle_chk("t5_rr");
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      a_hr = 1'b1;
      a_push(2'd3); a_push(2'd3); a_push(2'd3); a_push(2'd0);
      @(negedge clk);
      chk("t5_hv2", {31'h0, a_hv}, 32'h1);
      chk("t5_cnt", a_cnt, 32'h03000001);
      chk("t5_dom", {30'h0, a_dom}, 32'h3);
      @(posedge clk); #1;

      // randomized throttling against a window scoreboard
      foreach (mc[i]) mc[i] = 0;
      wins = 0;
      wcyc = 0;
      reported = 0;
      hold = 0;
      tmo = 0;
      while (wins < 1000 && !tmo) begin
         @(posedge clk); #1;
         c_bv = ($urandom_range(0, 9) < 7);
         v4   = 4'($urandom_range(0, 15));
         c_bc = v4[3:2];
         c_hr = ($urandom_range(0, 1) == 1);
         @(negedge clk);
         if (c_hv) begin
            if (hold) begin
               chk("rnd_hold_cnt", c_cnt, s_cnt);
               chk("rnd_hold_dom", {30'h0, c_dom}, {30'h0, s_dom});
               chk("rnd_hold_sat", {31'h0, c_sat}, {31'h0, s_sat});
            end
            if (!reported) begin
               e_cnt = '0;
               best = 0;
               sum = 0;
               for (int i = 0; i < 4; i++) begin
                  e_cnt[i*8 +: 8] = 8'(mc[i]);
                  if (mc[i] > mc[best]) best = i;
                  sum += int'(c_cnt[i*8 +: 8]);
               end
               chk("rnd_cnt", c_cnt, e_cnt);
               chk("rnd_sum", 32'(sum), 32'd16);
               chk("rnd_dom", {30'h0, c_dom}, 32'(best));
               chk("rnd_sat", {31'h0, c_sat}, 32'h0);
               chk("rnd_br", {31'h0, c_br}, 32'h0);
               reported = 1;
            end
            hold  = !c_hr;
            s_cnt = c_cnt;
            s_dom = c_dom;
            s_sat = c_sat;
            if (c_hr) begin
               foreach (mc[i]) mc[i] = 0;
               reported = 0;
               wins++;
               wcyc = 0;
            end
         end else begin
            hold = 0;
            if (c_br && c_bv) mc[c_bc]++;
         end
         wcyc++;
         if (wcyc > 1000) begin
            chk("rnd_timeout", 32'(wcyc), 32'd1000);
            tmo = 1;
         end
      end
      c_bv = 1'b0;
      c_hr = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
